// File: rtl/nibble_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_pkg
// Brief    : Shared constants, FSM encoding and sizing helper for the
//            nibble-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package nibble_serial_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_t;

  // Counter width large enough to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl_if
// Brief    : Operand/result valid-ready bus of the nibble-serial adder.
//            NIBBLE_SERIAL_SUB_EN adds the Sub operand-side control.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic             Sub;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );
  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
`else
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );
  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
`endif
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_slice_add.sv
`default_nettype none
// ============================================================================
// Module   : nibble_slice_add
// Brief    : 4-bit ripple-carry adder built from four full-adder cells.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_slice_add
  import nibble_serial_pkg::*;
(
  input  wire logic [SLICE_W-1:0] A,
  input  wire logic [SLICE_W-1:0] B,
  input  wire logic               Cin,
  output logic      [SLICE_W-1:0] Sum,
  output logic                    Cout,
  output logic                    C3
);

  logic [SLICE_W:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[SLICE_W];
  // Carry into the top bit; XOR with Cout gives signed overflow of the MSB nibble.
  assign C3   = w_c[SLICE_W-1];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock.
//            NIBBLE_SERIAL_SUB_EN enables A-B via the Sub operand bit.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input wire logic                 clk,
  input wire logic                 rst,
  nibble_serial_add_ctrl_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  ser_state_t         r_state;
  ser_state_t         w_nxt_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-SLICE_W-1:0] r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_nib_sum;
  logic               w_nib_cout;
  logic               w_nib_c3;
  logic [WIDTH-1:0]   w_shift;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_c_load;

`ifdef NIBBLE_SERIAL_SUB_EN
  // Subtract as A + ~B + 1; Cin is not used in that mode.
  assign w_b_load = bus.Sub ? ~bus.B : bus.B;
  assign w_c_load = bus.Sub ? 1'b1   : bus.Cin;
`else
  assign w_b_load = bus.B;
  assign w_c_load = bus.Cin;
`endif

  nibble_slice_add u_slice (
    .A    (r_a[SLICE_W-1:0]),
    .B    (r_b[SLICE_W-1:0]),
    .Cin  (r_carry),
    .Sum  (w_nib_sum),
    .Cout (w_nib_cout),
    .C3   (w_nib_c3)
  );

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);
  // Earlier nibbles sit in r_acc; on the last step this is the full result.
  assign w_shift  = {w_nib_sum, r_acc};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_nxt_state = RUN;
      RUN:     if (w_last)        w_nxt_state = DONE;
      DONE:    if (bus.out_ready) w_nxt_state = IDLE;
      default:                    w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.A;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> SLICE_W;
      r_b     <= r_b >> SLICE_W;
      r_acc   <= w_shift[WIDTH-1:SLICE_W];
      r_carry <= w_nib_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_shift;
        r_cout <= w_nib_cout;
        r_ovf  <= w_nib_c3 ^ w_nib_cout;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.Sum       = r_sum;
  assign bus.Cout      = r_cout;
  assign bus.Ovf       = r_ovf;

endmodule
`default_nettype wire
